// File: rtl/cpu_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// read-return owner tags and default bus widths.
package cpu_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // Access sequencing states; one RAM access is issued per ACC_* cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC_CPU = 2'd1,
    ACC_VID = 2'd2
  } state_e;

  // Tag carried alongside an in-flight read so its data returns to the right port.
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side memory port: req/gnt handshake plus registered read return.
// The requester drives through the master modport; the arbiter takes slave.
interface mem_port_arbiter_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (output req, we, addr, wr_data, input gnt, rd_valid, rd_data);
  modport slave  (input req, we, addr, wr_data, output gnt, rd_valid, rd_data);

endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way winner select between the CPU and video requesters.
// Default build: round robin on ties, remembering the last winner.
// With ARB_CPU_PRIORITY_EN defined: CPU wins ties unless video has lost
// STARVE_LIMIT ties in a row, in which case video wins the next tie.
module arb_rr2
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   cpu_req,
  input  logic   vid_req,
  output logic   any_req,
  output owner_e winner
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("arb_rr2: STARVE_LIMIT must be at least 1");
  end

  logic tie;
  assign tie = cpu_req & vid_req;

`ifdef ARB_CPU_PRIORITY_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             vid_starved;
  assign vid_starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Count ties video has lost since its last grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (any_req) begin
      if (winner == OWN_VID) starve_cnt <= '0;
      else if (tie)          starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  owner_e last_winner;

  // Remember who won the most recent grant; video at reset so the CPU takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_winner <= OWN_VID;
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    else if (any_req) last_winner <= winner;
  end
`endif

  // Pick this edge's winner from the pending requests.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    any_req = cpu_req | vid_req;
    winner  = OWN_CPU;
    if (tie) begin
`ifdef ARB_CPU_PRIORITY_EN
      winner = vid_starved ? OWN_VID : OWN_CPU;
`else
      winner = (last_winner == OWN_VID) ? OWN_CPU : OWN_VID;
`endif
    end else if (vid_req) begin
      winner = OWN_VID;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-latency block RAM between the CPU port and
// the video scan-out reader. One access per cycle, back-to-back grants allowed.
// Optional macro ARB_CPU_PRIORITY_EN switches ties from round robin to
// CPU priority with a video starvation limit.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  cpu,
  mem_port_arbiter_if.slave  vid,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wr_data,
  output logic               mem_we,
  input  logic [DATA_W-1:0]  mem_rd_data
);

  state_e            state, next_state;
  logic              any_req;
  owner_e            winner;
  logic              rd_pend;
  owner_e            rd_owner;
  logic              cpu_rd_valid, vid_rd_valid;
  logic [DATA_W-1:0] cpu_rd_hold, vid_rd_hold;

  arb_rr2 #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_req (cpu.req),
    .vid_req (vid.req),
    .any_req (any_req),
    .winner  (winner)
  );

  // Next access: go straight to the winner's access state, else idle.
  always_comb begin
    next_state = IDLE;
    if (any_req) next_state = (winner == OWN_CPU) ? ACC_CPU : ACC_VID;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Launch the winner's access into the RAM address/data/write-enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_we      <= 1'b0;
    end else begin
      unique case (next_state)
        ACC_CPU: begin
          mem_addr    <= cpu.addr;
          mem_wr_data <= cpu.wr_data;
          mem_we      <= cpu.we;
        end
        ACC_VID: begin
          mem_addr <= vid.addr;
          mem_we   <= 1'b0;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

  assign cpu.gnt = (state == ACC_CPU);
  assign vid.gnt = (state == ACC_VID);

  // Tag the read issued this cycle so its data returns to the right port next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_CPU;
    end else begin
      rd_pend  <= ((state == ACC_CPU) && !mem_we) || (state == ACC_VID);
      rd_owner <= (state == ACC_VID) ? OWN_VID : OWN_CPU;
    end
  end

  assign cpu_rd_valid = rd_pend && (rd_owner == OWN_CPU);
  assign vid_rd_valid = rd_pend && (rd_owner == OWN_VID);

  // Keep each port's last read word so rd_data holds between valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rd_hold <= '0;
      vid_rd_hold <= '0;
    end else begin
      if (cpu_rd_valid) cpu_rd_hold <= mem_rd_data;
      if (vid_rd_valid) vid_rd_hold <= mem_rd_data;
    end
  end

  // The RAM output register already provides the valid-cycle data; the hold
  // registers take over afterwards, so no extra cycle of latency is added.
  assign cpu.rd_valid = cpu_rd_valid;
  assign vid.rd_valid = vid_rd_valid;
  assign cpu.rd_data  = cpu_rd_valid ? mem_rd_data : cpu_rd_hold;
  assign vid.rd_data  = vid_rd_valid ? mem_rd_data : vid_rd_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a 256-word
// registered-read RAM model. Expected tie order follows ARB_CPU_PRIORITY_EN.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) vid_if ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu         (cpu_if),
    .vid         (vid_if),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_we      (mem_we),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten words read back a pattern derived from the address.
  logic [DATA_W-1:0] ram [256];
  bit   [255:0]      written;

  function automatic logic [DATA_W-1:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {8'hA5, a};
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr[7:0]]     <= mem_wr_data;
      written[mem_addr[7:0]] <= 1'b1;
    end
    mem_rd_data <= written[mem_addr[7:0]] ? ram[mem_addr[7:0]] : init_val(mem_addr[7:0]);
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] exp_cpu;
`ifdef ARB_CPU_PRIORITY_EN
    exp_cpu = 10'b0111101111;
`else
    exp_cpu = 10'b0101010101;
`endif

    // Reset with both requests high: every output stays 0.
    rst_n          = 1'b0;
    cpu_if.req     = 1'b1;
    cpu_if.we      = 1'b0;
    cpu_if.addr    = 16'h0000;
    cpu_if.wr_data = 16'h0000;
    vid_if.req     = 1'b1;
    vid_if.we      = 1'b0;
    vid_if.addr    = 16'h0040;
    vid_if.wr_data = 16'h0000;
    step();
    step();
    check("rst_gnt",      {cpu_if.gnt, vid_if.gnt}, 0);
    check("rst_rd_valid", {cpu_if.rd_valid, vid_if.rd_valid}, 0);
    check("rst_rd_data",  {cpu_if.rd_data, vid_if.rd_data}, 0);
    check("rst_mem",      {mem_addr, mem_wr_data}, 0);
    check("rst_mem_we",   mem_we, 0);

    // First tie after release goes to the CPU.
    rst_n = 1'b1;
    step();
    check("first_cpu_gnt", cpu_if.gnt, 1);
    check("first_vid_gnt", vid_if.gnt, 0);
    cpu_if.req = 1'b0;
    vid_if.req = 1'b0;
    step();
    check("first_cpu_valid", cpu_if.rd_valid, 1);
    check("first_cpu_data",  cpu_if.rd_data, 16'hA500);
    check("first_idle_gnt",  {cpu_if.gnt, vid_if.gnt}, 0);
    step();

    // CPU-only read of 0x0010.
    cpu_if.req  = 1'b1;
    cpu_if.addr = 16'h0010;
    step();
    check("rd_gnt",      cpu_if.gnt, 1);
    check("rd_mem_addr", mem_addr, 16'h0010);
    check("rd_mem_we",   mem_we, 0);
    cpu_if.req = 1'b0;
    step();
    check("rd_valid", cpu_if.rd_valid, 1);
    check("rd_data",  cpu_if.rd_data, 16'hBEEF);
    step();
    check("rd_valid_pulse", cpu_if.rd_valid, 0);
    check("rd_data_hold",   cpu_if.rd_data, 16'hBEEF);

    // CPU write 0x1234 to 0x0020, then read it back.
    cpu_if.req     = 1'b1;
    cpu_if.we      = 1'b1;
    cpu_if.addr    = 16'h0020;
    cpu_if.wr_data = 16'h1234;
    step();
    check("wr_gnt",     cpu_if.gnt, 1);
    check("wr_mem_we",  mem_we, 1);
    check("wr_addr",    mem_addr, 16'h0020);
    check("wr_data",    mem_wr_data, 16'h1234);
    cpu_if.req = 1'b0;
    cpu_if.we  = 1'b0;
    step();
    check("wr_we_pulse", mem_we, 0);
    check("wr_no_valid", cpu_if.rd_valid, 0);
    step();
    check("wr_no_valid2", cpu_if.rd_valid, 0);
    cpu_if.req = 1'b1;
    step();
    check("rb_gnt", cpu_if.gnt, 1);
    cpu_if.req = 1'b0;
    step();
    check("rb_valid", cpu_if.rd_valid, 1);
    check("rb_data",  cpu_if.rd_data, 16'h1234);

    // Video-only read of 0x0040.
    vid_if.req  = 1'b1;
    vid_if.addr = 16'h0040;
    step();
    check("vid_gnt",    vid_if.gnt, 1);
    check("vid_addr",   mem_addr, 16'h0040);
    check("vid_mem_we", mem_we, 0);
    vid_if.req = 1'b0;
    step();
    check("vid_valid",    vid_if.rd_valid, 1);
    check("vid_data",     vid_if.rd_data, 16'hA540);
    check("vid_cpu_none", cpu_if.rd_valid, 0);

    // Both requesting continuously: one grant every cycle in the expected order.
    cpu_if.req  = 1'b1;
    cpu_if.addr = 16'h0030;
    vid_if.req  = 1'b1;
    vid_if.addr = 16'h0041;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("cont_cpu_gnt%0d", i), cpu_if.gnt, exp_cpu[i]);
      check($sformatf("cont_vid_gnt%0d", i), vid_if.gnt, !exp_cpu[i]);
      check($sformatf("cont_mem_we%0d", i), mem_we, 0);
      if (i > 0) begin
        check($sformatf("cont_cpu_valid%0d", i), cpu_if.rd_valid, exp_cpu[i-1]);
        check($sformatf("cont_vid_valid%0d", i), vid_if.rd_valid, !exp_cpu[i-1]);
        if (exp_cpu[i-1]) check($sformatf("cont_cpu_data%0d", i), cpu_if.rd_data, 16'hA530);
        else              check($sformatf("cont_vid_data%0d", i), vid_if.rd_data, 16'hA541);
      end
    end
    cpu_if.req = 1'b0;
    vid_if.req = 1'b0;
    step();
    check("cont_end_gnt",       {cpu_if.gnt, vid_if.gnt}, 0);
    check("cont_end_cpu_valid", cpu_if.rd_valid, exp_cpu[9]);
    check("cont_end_vid_valid", vid_if.rd_valid, !exp_cpu[9]);
    step();

    // Reset pulsed during a video grant cycle drops the in-flight read.
    vid_if.req  = 1'b1;
    vid_if.addr = 16'h0042;
    step();
    check("mid_vid_gnt", vid_if.gnt, 1);
    vid_if.req = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("mid_rst_gnt",    {cpu_if.gnt, vid_if.gnt}, 0);
    check("mid_rst_mem_we", mem_we, 0);
    step();
    check("mid_rst_valid", {cpu_if.rd_valid, vid_if.rd_valid}, 0);
    rst_n = 1'b1;
    step();
    check("mid_post_valid", {cpu_if.rd_valid, vid_if.rd_valid}, 0);
    check("mid_post_gnt",   {cpu_if.gnt, vid_if.gnt}, 0);

    // Resume: CPU read of the earlier write, then a video read.
    cpu_if.req  = 1'b1;
    cpu_if.addr = 16'h0020;
    step();
    check("res_cpu_gnt", cpu_if.gnt, 1);
    cpu_if.req = 1'b0;
    step();
    check("res_cpu_valid", cpu_if.rd_valid, 1);
    check("res_cpu_data",  cpu_if.rd_data, 16'h1234);
    vid_if.req = 1'b1;
    step();
    check("res_vid_gnt", vid_if.gnt, 1);
    vid_if.req = 1'b0;
    step();
    check("res_vid_valid", vid_if.rd_valid, 1);
    check("res_vid_data",  vid_if.rd_data, 16'hA542);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port block RAM (1-cycle registered read latency) between the CPU load/store/fetch port and the video scan-out reader.
- Sits between the CPU memory interface and the RAM, and between the video pixel fetcher and the RAM.
- One RAM access per cycle. Access sequencing is a small FSM with a req/gnt/valid handshake per requester.

Parameters:
- ADDR_W, 16, address width of both ports and the RAM.
- DATA_W, 16, data width.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which video wins (priority mode only).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- CpuReq  input  1  CPU access request; held until CpuGnt.
- CpuWe  input  1  1 = write, 0 = read; sampled with CpuReq.
- CpuAddr  input  ADDR_W  CPU address.
- CpuWrData  input  DATA_W  CPU write data.
- CpuGnt  output  1  one-cycle pulse: CPU request accepted.
- CpuRdValid  output  1  one-cycle pulse: CpuRdData valid.
- CpuRdData  output  DATA_W  CPU read data.
- VidReq  input  1  video read request; held until VidGnt.
- VidAddr  input  ADDR_W  video address.
- VidGnt  output  1  one-cycle pulse: video request accepted.
- VidRdValid  output  1  one-cycle pulse: VidRdData valid.
- VidRdData  output  DATA_W  video read data.
- MemAddr  output  ADDR_W  registered RAM address.
- MemWrData  output  DATA_W  registered RAM write data.
- MemWe  output  1  registered RAM write enable.
- MemRdData  input  DATA_W  RAM read data, valid 1 cycle after MemAddr.

Behaviour:
- Reset (Reset low, async): FSM = IDLE, every output 0, LastWinner = VID so the CPU wins the first tie, StarveCnt = 0.
- FSM states: IDLE, ACC_CPU, ACC_VID.
  - Each edge, from any state: if a request is pending, the next state is ACC_<winner>; otherwise IDLE.
  - Back-to-back accesses are allowed; no dead cycle between grants.
- Timing, request seen high at edge N:
  - Edge N latches the winner's address, data and write enable into MemAddr/MemWrData/MemWe.
  - Gnt is high during cycle N+1 (the cycle after edge N).
  - Edge N+1: for a read, the RAM produces MemRdData.
  - RdValid is high with RdData during cycle N+2. RdData is registered and holds its value until the next RdValid.
- Requester rule: Req/Addr/We/WrData stay stable until Gnt is seen. A Req still high in the Gnt cycle counts as a new request.
- The loser's Req stays pending, and it competes again on the next edge.
- Video is read-only: MemWe is always 0 on video grants.
- CPU writes: MemWe is high for exactly one cycle and no CpuRdValid is produced.
- Tie (both Req high) in default mode: round robin. The winner is the opposite of LastWinner, and LastWinner updates on every grant.
- MemWe returns to 0 in any cycle without a CPU write grant. MemAddr holds its last value when IDLE.
- RdValid is routed by a registered owner tag, so an in-flight read completes to the correct port even if the next grant goes to the other port.
- Reset asserted mid-access: the in-flight read is dropped, no RdValid is emitted, and MemWe clears immediately.

Optional Feature:
- Macro ARB_CPU_PRIORITY_EN.
  - Defined: the CPU wins every tie. StarveCnt increments each time video loses a tie and clears on any video grant. When StarveCnt == STARVE_LIMIT, video wins the next tie.
  - Undefined: pure round robin as above; StarveCnt and STARVE_LIMIT are unused.

Decomposition:
- Shared package (cpu_pkg): FSM state encoding (IDLE/ACC_CPU/ACC_VID), owner-tag constants OWN_CPU/OWN_VID, default ADDR_W/DATA_W.
- One natural sub-module, arb_rr2: a 2-way winner select with LastWinner/StarveCnt state. The top module holds the FSM, address/data registers and the read-return pipeline.

Test Plan:
- Reset with Req inputs high -> all outputs 0 while Reset is low. After release, CPU is granted first (CpuGnt 1 cycle after the first edge).
- CPU-only read of addr 0x0010, RAM model returning 0xBEEF -> MemAddr=0x0010 and CpuGnt at N+1; CpuRdValid with 0xBEEF at N+2.
- CPU write 0x1234 to 0x0020 -> MemWe high for exactly 1 cycle with MemAddr=0x0020 and MemWrData=0x1234; no CpuRdValid. A later read returns 0x1234.
- Both requesting continuously, default build -> grants alternate CPU, VID, CPU, VID. Each RdValid goes to the correct port with the correct data; 100% RAM utilisation.
- ARB_CPU_PRIORITY_EN, STARVE_LIMIT=4, both requesting continuously -> 4 CPU grants, then 1 VID grant, repeating.
- Reset pulsed low in the cycle after a video grant -> no VidRdValid is emitted. MemWe=0, and operation resumes cleanly after release.
